// File: rtl/ps2_rx_events.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_events
// Description : PS/2 keyboard receiver. Synchronises and de-glitches the raw
//               PS/2 lines, frames 11-bit packets (odd parity, stop bit,
//               inactivity timeout) and folds E0/F0 prefixes into single
//               make/break events queued in a first-word-fall-through FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_events #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ps2clk,
    input  logic                     ps2data,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [7:0]               ev_code,
    output logic                     ev_ext,
    output logic                     ev_brk,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     frame_err,
    output logic                     overflow
);

    localparam int c_FCW = $clog2(FILTER_LEN + 1);
    localparam int c_TCW = $clog2(TIMEOUT + 1);
    localparam int c_AW  = $clog2(DEPTH);
    localparam int c_CW  = c_AW + 1;

    localparam logic [c_FCW-1:0] c_FILT_LAST = c_FCW'(FILTER_LEN - 1);
    localparam logic [c_TCW-1:0] c_TO_MAX    = c_TCW'(TIMEOUT);
    localparam logic [c_CW-1:0]  c_FULL      = c_CW'(DEPTH);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DATA   = 2'd1;
    localparam logic [1:0] c_PARITY = 2'd2;
    localparam logic [1:0] c_STOP   = 2'd3;

    // Bit 0 carries the clock line, bit 1 the data line throughout.
    logic [1:0] w_raw;
    logic [1:0] r_meta;
    logic [1:0] r_sync;
    logic [1:0] w_filt;

    assign w_raw = {ps2data, ps2clk};

    // Two-flop synchroniser; idle-high lines so reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 2'b11;
            r_sync <= 2'b11;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filter
            logic [c_FCW-1:0] r_cnt;
            logic             r_lvl;

            // Filtered level follows the synchronised line only after
            // FILTER_LEN consecutive cycles of disagreement.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_lvl <= 1'b1;
                end else if (r_sync[gi] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_FILT_LAST) begin
                    r_cnt <= '0;
                    r_lvl <= r_sync[gi];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_filt[gi] = r_lvl;
        end
    endgenerate

    logic r_clk_d;
    logic w_fall;

    // Delayed filtered clock for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) r_clk_d <= 1'b1;
        else     r_clk_d <= w_filt[0];
    end

    assign w_fall = r_clk_d & ~w_filt[0];

    logic [1:0]       r_state;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic [c_TCW-1:0] r_to_cnt;
    logic             r_byte_valid;
    logic             r_byte_bad;
    logic [7:0]       r_byte;

    // Frame FSM with inactivity timeout; emits one-cycle good/bad byte strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_to_cnt     <= '0;
            r_byte_valid <= 1'b0;
            r_byte_bad   <= 1'b0;
            r_byte       <= '0;
        end else begin
            r_byte_valid <= 1'b0;
            r_byte_bad   <= 1'b0;

            if (r_state == c_IDLE || w_fall) r_to_cnt <= '0;
            else                             r_to_cnt <= r_to_cnt + 1'b1;

            if (r_state != c_IDLE && !w_fall && r_to_cnt == c_TO_MAX) begin
                r_state    <= c_IDLE;
                r_to_cnt   <= '0;
                r_byte_bad <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    c_IDLE: begin
                        if (!w_filt[1]) begin
                            r_state  <= c_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    c_DATA: begin
                        r_shift  <= {w_filt[1], r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7) r_state <= c_PARITY;
                    end
                    c_PARITY: begin
                        r_parity <= w_filt[1];
                        r_state  <= c_STOP;
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_byte  <= r_shift;
                        if (w_filt[1] && (^{r_shift, r_parity})) r_byte_valid <= 1'b1;
                        else                                     r_byte_bad   <= 1'b1;
                    end
                endcase
            end
        end
    end

    logic            r_ext;
    logic            r_brk;
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic [9:0]      r_mem [DEPTH];

    logic w_is_e0;
    logic w_is_f0;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_wr;

    assign w_is_e0 = (r_byte == 8'hE0);
    assign w_is_f0 = (r_byte == 8'hF0);
    assign w_push  = r_byte_valid & ~w_is_e0 & ~w_is_f0;
    assign w_pop   = (r_count != '0) & ev_ready;
    assign w_full  = (r_count == c_FULL);
    assign w_wr    = w_push & (~w_full | w_pop);

    // Prefix folding, error/overflow pulses and FIFO pointer bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= r_byte_bad;
            overflow  <= w_push & w_full & ~w_pop;

            if (r_byte_bad) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (r_byte_valid) begin
                if (w_is_e0) begin
                    r_ext <= 1'b1;
                end else if (w_is_f0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end

            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;

            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Event storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= {r_byte, r_ext, r_brk};
    end

    logic [9:0] w_head;

    assign w_head   = r_mem[r_rptr];
    assign ev_valid = (r_count != '0);
    assign ev_count = r_count;
    assign {ev_code, ev_ext, ev_brk} = ev_valid ? w_head : 10'd0;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_events.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx_events
// Description : Self-checking bench for ps2_rx_events. PS/2 frames are driven
//               at bit level and compared against an event-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_events;

    localparam int F    = 4;
    localparam int TO   = 300;
    localparam int D    = 4;
    localparam int HALF = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ps2clk = 1'b1;
    logic              ps2data = 1'b1;
    logic              ev_valid;
    logic              ev_ready = 1'b0;
    logic [7:0]        ev_code;
    logic              ev_ext;
    logic              ev_brk;
    logic [$clog2(D):0] ev_count;
    logic              frame_err;
    logic              overflow;

    ps2_rx_events #(.FILTER_LEN(F), .TIMEOUT(TO), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2clk    (ps2clk),
        .ps2data   (ps2data),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_brk    (ev_brk),
        .ev_count  (ev_count),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_ferr = 0;
    int n_ovf = 0;
    int exp_ferr_tot = 0;
    int exp_ovf_tot = 0;

    // Model state: queued events {code, ext, brk} and pending prefixes.
    logic [9:0] exp_q[$];
    bit m_ext = 1'b0;
    bit m_brk = 1'b0;

    always @(negedge clk) begin
        if (frame_err === 1'b1) n_ferr++;
        if (overflow === 1'b1)  n_ovf++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~(^b) ^ bad_par;
        return {~bad_stop, p, b, 1'b0};
    endfunction

    function automatic bit frame_good(input logic [10:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && ($countones(f[9:1]) % 2 == 1);
    endfunction

    // Event-level reference: applies one received byte (and an optional
    // concurrent pop) and reports expected error/overflow pulses.
    task automatic model_frame(input logic [7:0] b, input bit good, input bit pop_now,
                               output bit e_ferr, output bit e_ovf);
        bit popped;
        bit full;
        popped = pop_now && (exp_q.size() > 0);
        full   = (exp_q.size() == D);
        e_ferr = 1'b0;
        e_ovf  = 1'b0;
        if (popped) void'(exp_q.pop_front());
        if (!good) begin
            e_ferr = 1'b1;
            m_ext  = 1'b0;
            m_brk  = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (full && !popped) e_ovf = 1'b1;
            else                 exp_q.push_back({b, m_ext, m_brk});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        if (e_ferr) exp_ferr_tot++;
        if (e_ovf)  exp_ovf_tot++;
    endtask

    task automatic check_head(input string tag);
        chk({tag, "_count"}, 32'(ev_count), exp_q.size());
        chk({tag, "_valid"}, 32'(ev_valid), (exp_q.size() > 0) ? 1 : 0);
        if (exp_q.size() > 0) begin
            chk({tag, "_code"}, 32'(ev_code), 32'(exp_q[0][9:2]));
            chk({tag, "_ext"},  32'(ev_ext),  32'(exp_q[0][1]));
            chk({tag, "_brk"},  32'(ev_brk),  32'(exp_q[0][0]));
        end
    endtask

    task automatic pop_one();
        check_head("pop_head");
        ev_ready = 1'b1;
        cyc(1);
        ev_ready = 1'b0;
        void'(exp_q.pop_front());
        chk("pop_count", 32'(ev_count), exp_q.size());
    endtask

    task automatic pop_all();
        while (exp_q.size() > 0) pop_one();
    endtask

    // Drives the first nbits of frame f. A nonzero glitch inserts short
    // pulses on both lines; pop_at raises ev_ready exactly on the push cycle.
    task automatic send_frame(input logic [10:0] f, input int nbits, input int glitch, input bit pop_at);
        bit ef;
        bit eo;
        for (int i = 0; i < nbits; i++) begin
            ps2data = f[i];
            cyc(HALF / 2);
            ps2clk = 1'b0;
            if (i == 10) begin
                cyc(F + 3);
                check_head("pre_push");
                ev_ready = pop_at;
                cyc(1);
                ev_ready = 1'b0;
                model_frame(f[8:1], frame_good(f), pop_at, ef, eo);
                chk("frame_err_pulse", 32'(frame_err), 32'(ef));
                chk("overflow_pulse", 32'(overflow), 32'(eo));
                check_head("post_push");
                cyc(HALF - (F + 4));
            end else if (glitch > 0 && i == 6) begin
                ps2data = ~f[i];
                cyc(glitch);
                ps2data = f[i];
                cyc(HALF - glitch);
            end else begin
                cyc(HALF);
            end
            ps2clk = 1'b1;
            if (glitch > 0 && i == 4) begin
                cyc(5);
                ps2clk = 1'b0;
                cyc(glitch);
                ps2clk = 1'b1;
                cyc(HALF - 5 - glitch);
            end else begin
                cyc(HALF);
            end
        end
        ps2data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(mk(b, 1'b0, 1'b0), 11, 0, 1'b0);
    endtask

    initial begin
        logic [7:0] b;
        int g;

        // Reset state
        @(posedge clk);
        #1;
        cyc(3);
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_count", 32'(ev_count), 0);
        chk("rst_code", 32'(ev_code), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        cyc(10);

        // Single make code with exact latency check
        send_byte(8'h1C);
        chk("first_code", 32'(ev_code), 32'h1C);
        pop_all();

        // Extended release, then plain make
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        chk("ext_brk_count", 32'(ev_count), 1);
        chk("ext_brk_flags", 32'({ev_ext, ev_brk}), 32'b11);
        send_byte(8'h75);
        pop_all();

        // Parity and stop errors; flags cleared by an error
        send_byte(8'hF0);
        send_frame(mk(8'h1C, 1'b1, 1'b0), 11, 0, 1'b0);
        send_frame(mk(8'h1C, 1'b0, 1'b1), 11, 0, 1'b0);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        pop_all();

        // Inactivity timeout aborts a partial frame and clears prefixes
        send_byte(8'hF0);
        send_frame(mk(8'h29, 1'b0, 1'b0), 3, 0, 1'b0);
        cyc(TO + 40);
        exp_ferr_tot++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        chk("timeout_ferr", 32'(n_ferr), 32'(exp_ferr_tot));
        send_byte(8'h29);
        pop_all();

        // Overflow with consumer stalled, then pop coincident with full push
        for (int i = 0; i < D + 1; i++) send_byte(8'h10 + 8'(i));
        chk("ovf_count", 32'(ev_count), D);
        chk("ovf_total", 32'(n_ovf), 32'(exp_ovf_tot));
        pop_all();
        for (int i = 0; i < D; i++) send_byte(8'h30 + 8'(i));
        send_frame(mk(8'h3F, 1'b0, 1'b0), 11, 0, 1'b1);
        chk("full_pop_count", 32'(ev_count), D);
        pop_all();

        // Sub-filter glitches on both lines leave bytes intact
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(8'h01, 8'hDF));
            g = $urandom_range(1, F - 1);
            send_frame(mk(b, 1'b0, 1'b0), 11, g, 1'b0);
            pop_all();
        end

        // Randomised traffic including prefixes, errors and concurrent pops
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: b = 8'($urandom);
            endcase
            send_frame(mk(b, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0), 11, 0,
                       $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0 && exp_q.size() > 0) pop_one();
        end
        pop_all();

        // Reset in the middle of a frame
        send_byte(8'hE0);
        send_byte(8'h44);
        send_frame(mk(8'h66, 1'b0, 1'b0), 5, 0, 1'b0);
        rst = 1'b1;
        cyc(2);
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        chk("midrst_valid", 32'(ev_valid), 0);
        chk("midrst_count", 32'(ev_count), 0);
        chk("midrst_code", 32'(ev_code), 0);
        chk("midrst_ext", 32'(ev_ext), 0);
        rst = 1'b0;
        cyc(TO + 40);
        send_byte(8'h5A);
        pop_all();

        cyc(20);
        chk("ferr_total", 32'(n_ferr), 32'(exp_ferr_tot));
        chk("ovf_total_end", 32'(n_ovf), 32'(exp_ovf_tot));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
